// File: rtl/vga_game_defs_pkg.sv
// Definitions shared between the move-command front end and the pixel generator:
// mode encodings, move-step width and the sprite playfield limits.
package vga_game_defs_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_HOLD = 2'd1,
        MODE_FAST = 2'd2
    } mode_e;

    localparam int unsigned STEP_W = 10;
    localparam int unsigned X_MAX  = 639;
    localparam int unsigned Y_MAX  = 479;

    // Magnitude to signed two's-complement step of STEP_W bits.
    function automatic logic signed [STEP_W-1:0] to_step(input int unsigned mag, input logic neg);
        logic signed [STEP_W-1:0] m;
        m = STEP_W'(mag);
        return neg ? -m : m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input: 2-flop synchronizer followed by a stability counter that
// only lets the debounced level follow after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/move_cmd_ctrl.sv
// Sprite move-command controller: debounced buttons -> one signed (dx, dy) per taken frame tick,
// offered over valid/ready. Define ACCEL_EN to enable hold-to-accelerate (FAST mode, FAST_STEP).
module move_cmd_ctrl
    import vga_game_defs_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned STEP            = 5
`ifdef ACCEL_EN
    ,
    parameter int unsigned FAST_STEP       = 10,
    parameter int unsigned ACCEL_FRAMES    = 30
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btnU,
    input  logic                     btnL,
    input  logic                     btnD,
    input  logic                     btnR,
    input  logic                     frame_tick,
    input  logic                     mv_ready,
    output logic                     mv_valid,
    output logic signed [STEP_W-1:0] mv_dx,
    output logic signed [STEP_W-1:0] mv_dy,
    output logic [3:0]               btn_state,
    output logic [1:0]               mode
);

    logic [3:0] btn_db;  // {U,L,D,R}

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (.clk(clk), .reset(reset), .btn_raw(btnU), .btn_db(btn_db[3]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (.clk(clk), .reset(reset), .btn_raw(btnL), .btn_db(btn_db[2]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (.clk(clk), .reset(reset), .btn_raw(btnD), .btn_db(btn_db[1]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (.clk(clk), .reset(reset), .btn_raw(btnR), .btn_db(btn_db[0]));

    function automatic logic signed [STEP_W-1:0] axis_step(input logic pos, input logic neg,
                                                           input int unsigned mag);
        if (pos) return to_step(mag, 1'b0);
        if (neg) return to_step(mag, 1'b1);
        return '0;
    endfunction

    logic right, left, down, up, active, take, emit;
    logic [3:0]  dir;
    int unsigned step_mag;

    mode_e                    state_q, state_d;
    logic                     mv_valid_q, mv_valid_d;
    logic signed [STEP_W-1:0] dx_q, dx_d;
    logic signed [STEP_W-1:0] dy_q, dy_d;

`ifdef ACCEL_EN
    localparam int unsigned HC_W = $clog2(ACCEL_FRAMES + 1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(ACCEL_FRAMES);
    localparam logic [HC_W-1:0] HC_ONE = HC_W'(1);

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]      dir_q, dir_d;
    logic            same_dir;

    function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] c);
        return (c >= HC_MAX) ? c : c + HC_ONE;
    endfunction
`endif

    // Opposing buttons on one axis cancel to zero.
    always_comb begin
        right  = btn_db[0] & ~btn_db[2];
        left   = btn_db[2] & ~btn_db[0];
        down   = btn_db[1] & ~btn_db[3];
        up     = btn_db[3] & ~btn_db[1];
        dir    = {up, left, down, right};
        active = |dir;
        take   = frame_tick && (!mv_valid_q || mv_ready);
    end

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        step_mag = STEP;
`ifdef ACCEL_EN
        hold_cnt_d = hold_cnt_q;
        dir_d      = dir_q;
        same_dir   = (dir == dir_q);
`endif
        if (take) begin
            if (!active) begin
                state_d = MODE_IDLE;
`ifdef ACCEL_EN
                hold_cnt_d = '0;
`endif
            end else begin
                emit    = 1'b1;
                state_d = MODE_HOLD;
`ifdef ACCEL_EN
                dir_d      = dir;
                hold_cnt_d = HC_ONE;
                if (same_dir && state_q == MODE_FAST) begin
                    state_d    = MODE_FAST;
                    step_mag   = FAST_STEP;
                    hold_cnt_d = hold_cnt_q;
                end else if (same_dir && state_q == MODE_HOLD) begin
                    if (hold_cnt_q < HC_MAX) begin
                        hold_cnt_d = sat_inc(hold_cnt_q);
                    end else begin
                        state_d    = MODE_FAST;
                        step_mag   = FAST_STEP;
                        hold_cnt_d = hold_cnt_q;
                    end
                end
`endif
            end
        end
    end

    // A load on a taken tick overrides the retire of the previous command.
    always_comb begin
        mv_valid_d = mv_valid_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        if (mv_valid_q && mv_ready) begin
            mv_valid_d = 1'b0;
        end
        if (emit) begin
            mv_valid_d = 1'b1;
            dx_d       = axis_step(right, left, step_mag);
            dy_d       = axis_step(down, up, step_mag);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MODE_IDLE;
            mv_valid_q <= 1'b0;
            dx_q       <= '0;
            dy_q       <= '0;
`ifdef ACCEL_EN
            hold_cnt_q <= '0;
            dir_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mv_valid_q <= mv_valid_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
`ifdef ACCEL_EN
            hold_cnt_q <= hold_cnt_d;
            dir_q      <= dir_d;
`endif
        end
    end

    assign mv_valid  = mv_valid_q;
    assign mv_dx     = dx_q;
    assign mv_dy     = dy_q;
    assign btn_state = btn_db;
    assign mode      = state_q;

endmodule
